// File: rtl/ahb_uart_tx_if.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | ahb_uart_tx_if : AHB-Lite slave-side bus bundle for ahb_uart_tx |
// | rev 1.0                                                         |
// +-----------------------------------------------------------------+
interface ahb_uart_tx_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic [1:0]  HRESP;

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        output HRDATA, HREADYOUT, HRESP
    );

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        input  HRDATA, HREADYOUT, HRESP
    );
endinterface
`default_nettype wire

// File: rtl/ahb_uart_tx.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | ahb_uart_tx : AHB-Lite slave with TX FIFO and 8N1 serializer    |
// | rev 1.0                                                         |
// +-----------------------------------------------------------------+
module ahb_uart_tx #(
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
    input  wire          clock,
    input  wire          Rst,
    ahb_uart_tx_if.slave bus,
    output logic         TX
);
    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // Address-phase capture
    logic       r_valid;
    logic [1:0] r_addr;
    logic       r_write;

    // FIFO and control registers
    logic [7:0]         r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] r_rptr;
    logic [c_CNT_W-1:0] r_count;
    logic               r_ovf;
    logic [15:0]        r_div;

    // Serializer
    state_t      r_state,   w_state_nxt;
    logic [15:0] r_timer,   w_timer_nxt;
    logic [2:0]  r_idx,     w_idx_nxt;
    logic [7:0]  r_shift,   w_shift_nxt;
    logic [15:0] r_div_lat, w_div_lat_nxt;
    logic        r_tx,      w_tx_nxt;

    logic        w_wr_dphase;
    logic        w_push_req;
    logic        w_push;
    logic        w_pop;
    logic        w_full;
    logic        w_empty;
    logic        w_busy;
    logic        w_bit_end;
    logic [31:0] w_cnt32;
    logic [31:0] w_status;
    logic        w_unused;

    assign w_wr_dphase = r_valid & r_write;
    assign w_push_req  = w_wr_dphase & (r_addr == 2'd0);
    assign w_full      = (r_count == c_CNT_W'(FIFO_DEPTH));
    assign w_empty     = (r_count == '0);
    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    assign w_push      = w_push_req & (~w_full | w_pop);
    assign w_busy      = (r_state != S_IDLE);
    assign w_bit_end   = (r_timer == r_div_lat - 16'd1);
    assign w_cnt32     = 32'(r_count);
    assign w_status    = {w_cnt32[27:0], r_ovf, w_empty, w_full, w_busy};

    assign w_unused = ^{bus.HADDR[31:4], bus.HADDR[1:0], bus.HSIZE,
                        bus.HWDATA[31:16], w_cnt32[31:28]};

    assign bus.HREADYOUT = 1'b1;
    assign bus.HRESP     = 2'b00;
    assign TX            = r_tx;

    always_ff @(posedge clock) begin
        if (Rst) begin
            r_valid <= 1'b0;
            r_addr  <= 2'd0;
            r_write <= 1'b0;
        end else begin
            r_valid <= bus.HSEL & bus.HREADY & bus.HTRANS[1];
            r_addr  <= bus.HADDR[3:2];
            r_write <= bus.HWRITE;
        end
    end

    always_comb begin
        bus.HRDATA = 32'd0;
        if (r_valid & ~r_write) begin
            case (r_addr)
                2'd1:    bus.HRDATA = w_status;
                2'd2:    bus.HRDATA = {16'd0, r_div};
                default: bus.HRDATA = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wptr] <= bus.HWDATA[7:0];
        end
    end

    always_ff @(posedge clock) begin
        if (Rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + c_PTR_W'(1);
            if (w_pop)  r_rptr <= r_rptr + c_PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (Rst) begin
            r_ovf <= 1'b0;
            r_div <= DEFAULT_DIV;
        end else begin
            if (w_push_req & w_full & ~w_pop) begin
                r_ovf <= 1'b1;
            end else if (w_wr_dphase & (r_addr == 2'd1) & bus.HWDATA[3]) begin
                r_ovf <= 1'b0;
            end
            if (w_wr_dphase & (r_addr == 2'd2)) begin
                r_div <= (bus.HWDATA[15:0] == 16'd0) ? 16'd1 : bus.HWDATA[15:0];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (Rst) begin
            r_state   <= S_IDLE;
            r_timer   <= 16'd0;
            r_idx     <= 3'd0;
            r_shift   <= 8'd0;
            r_div_lat <= DEFAULT_DIV;
            r_tx      <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_timer   <= w_timer_nxt;
            r_idx     <= w_idx_nxt;
            r_shift   <= w_shift_nxt;
            r_div_lat <= w_div_lat_nxt;
            r_tx      <= w_tx_nxt;
        end
    end

    // TX is registered from the next state so the line level tracks the state one-for-one.
    always_comb begin
        w_state_nxt   = r_state;
        w_timer_nxt   = r_timer;
        w_idx_nxt     = r_idx;
        w_shift_nxt   = r_shift;
        w_div_lat_nxt = r_div_lat;
        w_pop         = 1'b0;
        w_tx_nxt      = 1'b1;

        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop         = 1'b1;
                    w_shift_nxt   = r_mem[r_rptr];
                    w_div_lat_nxt = r_div;
                    w_timer_nxt   = 16'd0;
                    w_state_nxt   = S_START;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_timer_nxt = 16'd0;
                    w_idx_nxt   = 3'd0;
                    w_state_nxt = S_DATA;
                end else begin
                    w_timer_nxt = r_timer + 16'd1;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_timer_nxt = 16'd0;
                    if (r_idx == 3'd7) begin
                        w_state_nxt = S_STOP;
                    end else begin
                        w_idx_nxt = r_idx + 3'd1;
                    end
                end else begin
                    w_timer_nxt = r_timer + 16'd1;
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    w_timer_nxt = 16'd0;
                    if (!w_empty) begin
                        w_pop         = 1'b1;
                        w_shift_nxt   = r_mem[r_rptr];
                        w_div_lat_nxt = r_div;
                        w_state_nxt   = S_START;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_timer_nxt = r_timer + 16'd1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        case (w_state_nxt)
            S_START: w_tx_nxt = 1'b0;
            S_DATA:  w_tx_nxt = w_shift_nxt[w_idx_nxt];
            default: w_tx_nxt = 1'b1;
        endcase
    end
endmodule
`default_nettype wire

// File: doc/ahb_uart_tx.md
Name: ahb_uart_tx

Overview:
- AHB-Lite slave that sits between the AHB bus and the UART TX pin, replacing the direct HWDATA hookup in the top level.
- The CPU writes bytes over AHB into an 8-entry TX FIFO.
- An 8N1 serializer drains the FIFO at a programmable baud divisor.
- Status and divisor registers are readable and writable over the same slave port.

Parameters:
- FIFO_DEPTH, 8, TX FIFO entries; must be a power of 2.
- DEFAULT_DIV, 16'd434, reset value of the baud divisor (clocks per bit).

Ports:
- clock  input  1  system clock; all logic on the rising edge.
- Rst  input  1  synchronous, active-high reset.
- HSEL  input  1  slave select.
- HADDR  input  32  address; only [3:2] decoded.
- HTRANS  input  2  transfer type; NONSEQ/SEQ = HTRANS[1]=1.
- HWRITE  input  1  1 = write.
- HSIZE  input  3  ignored; all accesses treated as word.
- HWDATA  input  32  write data, valid in the data phase.
- HREADY  input  1  bus ready; qualifies the address phase.
- HRDATA  output  32  read data.
- HREADYOUT  output  1  slave ready; constant 1 (zero wait states).
- HRESP  output  2  constant 2'b00 (OKAY).
- TX  output  1  serial line; idle high.

Behaviour:
- Reset (Rst=1 at a clock edge):
  - TX=1, FIFO empty (pointers=0, count=0), FSM=IDLE, divisor=DEFAULT_DIV, overflow flag=0.
  - Address-phase registers cleared; HRDATA=0.
  - Reset mid-frame aborts the frame: TX=1 from the next cycle.
- Address phase:
  - Accepted when HSEL & HREADY & HTRANS[1].
  - Captures HADDR[3:2] and HWRITE, with a valid flag, into registers.
  - Data phase is the following cycle.
- Register map (offset from HADDR[3:2]):
  - 0x0 DATA:
    - Write pushes HWDATA[7:0] at the end of the data phase.
    - If the FIFO is full and no pop occurs that cycle, the byte is dropped and overflow is set to 1.
    - Reads return 0.
  - 0x4 STATUS (read):
    - bit0 busy (FSM != IDLE); bit1 full; bit2 empty; bit3 overflow (sticky); bits[7:4] count (0..8); others 0.
    - Writing with HWDATA[3]=1 clears overflow; other bits are ignored.
  - 0x8 DIV:
    - Read/write of [15:0]; upper bits read 0.
    - A written value of 0 is stored as 1.
  - 0xC: reads 0, writes ignored.
- HRDATA is driven combinationally in the data phase from the registered address and current register state; it is 0 when there is no valid read data phase.
- FIFO:
  - Circular buffer; read/write pointers wrap modulo FIFO_DEPTH; count tracked explicitly.
  - Simultaneous push and pop: both occur, count unchanged. This holds even when full, so the push succeeds and overflow is not set.
- TX FSM states: IDLE, START, DATA, STOP.
  - Bit timer counts 0..div_lat-1.
  - div_lat is latched from DIV when leaving IDLE or on STOP->START.
  - A DIV write mid-frame affects only the next frame.
  - IDLE: TX=1. If the FIFO is non-empty, pop into the shift register, latch the divisor, go to START.
  - START: TX=0 for div_lat cycles, then DATA with bit index 0.
  - DATA: TX = shift[idx], LSB first, div_lat cycles per bit; after bit 7 go to STOP.
  - STOP: TX=1 for div_lat cycles. At the end, if the FIFO is non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
  - TX is a registered output.
- Latency: a DATA write data phase in cycle N gives count=1 in cycle N+1, pop and START in N+1, and TX=0 from cycle N+2.
- Frame length is exactly 10*div_lat cycles.

Test Plan:
- Reset then idle:
  - Required: TX=1, HRDATA=0 on a STATUS read data phase.
  - Required: STATUS reads 0x04 (empty), DIV reads 434.
- DIV=4, write DATA=0xA5:
  - TX=0 starting 2 cycles after the data phase, held 4 cycles.
  - Then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then stop=1 for 4 cycles.
  - busy=1 throughout, 0 afterwards.
- DIV=2, 10 back-to-back DATA writes (0x00..0x09):
  - The first byte is popped immediately, so 8 more fill the FIFO.
  - The 10th write is dropped: STATUS = overflow|full|busy with count=8, i.e. 0x8B.
  - 9 frames sent contiguously with no idle cycles.
  - Writing STATUS with bit3=1 clears overflow.
- Full FIFO with a push in the same cycle as a STOP->START pop:
  - Byte accepted, count stays 8, overflow stays 0.
- DIV write of 0:
  - Reads back 1; frames are then 10 cycles long.
  - A DIV write during a frame does not change that frame's bit timing.
- Rst=1 mid-DATA bit:
  - Next cycle: TX=1, STATUS=0x04, DIV=434.
  - A subsequent write transmits correctly.
